// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the 3-requester round-robin arbiter.
//   arb_state_e     : controller states (IDLE, GRANT)
//   SEL_REQ0..2     : mux-select encodings driven onto select_o
//   ARB_N           : number of requesters
//   idx_next()      : index + 1 modulo ARB_N
//   idx_onehot()    : index -> one-hot grant vector
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int ARB_N = 3;

  localparam logic [1:0] SEL_REQ0 = 2'b00;
  localparam logic [1:0] SEL_REQ1 = 2'b01;
  localparam logic [1:0] SEL_REQ2 = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [1:0] idx_next(input logic [1:0] idx);
    return (idx == SEL_REQ2) ? SEL_REQ0 : idx + 2'd1;
  endfunction

  function automatic logic [ARB_N-1:0] idx_onehot(input logic [1:0] idx);
    return ARB_N'(1) << idx;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// -----------------------------------------------------------------------------
// arb_rr_pick
// Combinational round-robin picker. Searches req (with excl bits removed) in
// the order ptr, ptr+1, ptr+2 (mod 3) and reports the first asserted index.
//   req   [2:0] : request vector
//   ptr   [1:0] : index searched first
//   excl  [2:0] : requesters to ignore (the current owner during handoff)
//   found       : some non-excluded requester is asserted
//   idx   [1:0] : winning index (SEL_REQ0 when nothing is found)
// -----------------------------------------------------------------------------
module arb_rr_pick
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0] req,
  input  logic [1:0]       ptr,
  input  logic [ARB_N-1:0] excl,
  output logic             found,
  output logic [1:0]       idx
);

  logic [ARB_N-1:0] avail;

  assign avail = req & ~excl;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    found = 1'b0;
    idx   = SEL_REQ0;
    // Walk from the farthest offset back to ptr so the closest hit wins last.
    for (int off = ARB_N - 1; off >= 0; off--) begin
      int cand;
      cand = int'(ptr) + off;
      if (cand >= ARB_N) cand = cand - ARB_N;
      if (avail[cand]) begin
        found = 1'b1;
        idx   = 2'(cand);
      end
    end
  end

endmodule

// File: rtl/arb_rr_3to1.sv
// -----------------------------------------------------------------------------
// arb_rr_3to1
// Round-robin arbiter sharing one 3-to-1 datapath mux among three requesters.
// The grant is held while the owner keeps requesting; on release the priority
// pointer moves past the owner and the next requester is granted on the same
// edge (no idle bubble).
//   clk_i         : clock, rising edge
//   rst_i         : asynchronous reset, active low
//   req_i   [2:0] : level-sensitive requests, bit k = requester k
//   grant_o [2:0] : registered one-hot grant, 000 when idle
//   select_o[1:0] : mux select matching grant_o, 00 when idle
//   busy_o        : a grant is active
// Build option: define ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD
// consecutive cycles while another requester waits. Without it MAX_HOLD is
// only range-checked.
// -----------------------------------------------------------------------------
module arb_rr_3to1
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ARB_N-1:0] req_i,
  output logic [ARB_N-1:0] grant_o,
  output logic [1:0]       select_o,
  output logic             busy_o
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("arb_rr_3to1: MAX_HOLD must be in 1..255");
  end

  arb_state_e       state_q, state_d;
  logic [1:0]       owner_q, owner_d;   // doubles as select_o; 00 when idle
  logic [1:0]       ptr_q, ptr_d;
  logic [ARB_N-1:0] grant_q, grant_d;
  logic             new_grant;
  logic             expire;

  logic [1:0]       pick_ptr;
  logic [ARB_N-1:0] pick_excl;
  logic             pick_found;
  logic [1:0]       pick_idx;

  // One picker serves both cases: fresh arbitration from ptr while idle, and
  // the handoff search starting after the owner (owner masked) while granted.
  assign pick_ptr  = (state_q == GRANT) ? idx_next(owner_q)   : ptr_q;
  assign pick_excl = (state_q == GRANT) ? idx_onehot(owner_q) : '0;

  arb_rr_pick u_pick (
    .req   (req_i),
    .ptr   (pick_ptr),
    .excl  (pick_excl),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int               HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;

  // While granted, pick_found means someone other than the owner is waiting.
  assign expire = (hold_q == HOLD_LIM) && pick_found;

  // Saturating at MAX_HOLD-1 keeps the expiry armed, so a late competitor
  // preempts a long-running owner on its first pending cycle.
  always_comb begin
    hold_d = hold_q;
    if (new_grant || state_d == IDLE) begin
      hold_d = '0;
    end else if (hold_q != HOLD_LIM) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    new_grant = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d   = GRANT;
          owner_d   = pick_idx;
          grant_d   = idx_onehot(pick_idx);
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (!req_i[owner_q] || expire) begin
          ptr_d = idx_next(owner_q);
          if (pick_found) begin
            owner_d   = pick_idx;
            grant_d   = idx_onehot(pick_idx);
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
            owner_d = SEL_REQ0;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = SEL_REQ0;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      owner_q <= SEL_REQ0;
      ptr_q   <= SEL_REQ0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign grant_o  = grant_q;
  assign select_o = owner_q;
  assign busy_o   = (state_q == GRANT);

endmodule

// File: tb/tb_arb_rr_3to1.sv
// -----------------------------------------------------------------------------
// tb_arb_rr_3to1
// Directed bench for arb_rr_3to1 (MAX_HOLD = 4). A behavioural model tracks the
// owner as an integer and is compared with the DUT every falling edge; directed
// scenarios additionally check hand-computed grants.
// -----------------------------------------------------------------------------
module tb_arb_rr_3to1;

  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [2:0] req_i = 3'b000;
  logic [2:0] grant_o;
  logic [1:0] select_o;
  logic       busy_o;

  int n_vec  = 0;
  int n_fail = 0;

  arb_rr_3to1 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .grant_o  (grant_o),
    .select_o (select_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- behavioural model ----------------
  int m_owner = -1;   // -1 = idle
  int m_ptr   = 0;
  int m_hold  = 0;

  function automatic int find_winner(input logic [2:0] r, input int start,
                                     input int skip);
    for (int off = 0; off < 3; off++) begin
      int c;
      c = (start + off) % 3;
      if (r[c] && c != skip) return c;
    end
    return -1;
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    int  win;
    bit  rotate;
    if (!rst_i) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_hold  <= 0;
    end else if (m_owner < 0) begin
      win = find_winner(req_i, m_ptr, -1);
      if (win >= 0) begin
        m_owner <= win;
        m_hold  <= 0;
      end
    end else begin
      win    = find_winner(req_i, (m_owner + 1) % 3, m_owner);
      rotate = !req_i[m_owner] ||
               (TIMEOUT_ON && m_hold == MAX_HOLD - 1 && win >= 0);
      if (rotate) begin
        m_ptr   <= (m_owner + 1) % 3;
        m_owner <= win;
        m_hold  <= 0;
      end else if (m_hold < MAX_HOLD - 1) begin
        m_hold <= m_hold + 1;
      end
    end
  end

  always @(negedge clk_i) begin
    logic [2:0] e_grant;
    logic [1:0] e_sel;
    logic       e_busy;
    e_grant = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    e_sel   = (m_owner < 0) ? 2'b00  : 2'(m_owner);
    e_busy  = (m_owner >= 0);
    n_vec++;
    if (grant_o !== e_grant || select_o !== e_sel || busy_o !== e_busy) begin
      n_fail++;
      $display("FAIL model t=%0t: grant/sel/busy got %b/%b/%b expected %b/%b/%b",
               $time, grant_o, select_o, busy_o, e_grant, e_sel, e_busy);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [2:0] act,
                       input logic [2:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Wait for an edge (which samples the current req_i), then set the next req.
  task automatic clk_step(input logic [2:0] nxt);
    @(posedge clk_i);
    #2 req_i = nxt;
  endtask

  task automatic do_reset(input logic [2:0] r);
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    req_i = r;
    @(posedge clk_i);
    #3 rst_i = 1'b1;
  endtask

  logic [2:0] s2_req [10];
  logic [2:0] s2_exp [9];

  initial begin
    s2_req = '{3'b111, 3'b111, 3'b110, 3'b111, 3'b101,
               3'b111, 3'b011, 3'b111, 3'b110, 3'b111};
    s2_exp = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100,
               3'b100, 3'b001, 3'b001, 3'b010};

    // Reset state
    #3;
    check("reset_grant", grant_o, 3'b000);
    check("reset_sel",   {1'b0, select_o}, 3'b000);
    check("reset_busy",  {2'b00, busy_o}, 3'b000);

    // Single request from idle, then release back to idle
    do_reset(3'b000);
    clk_step(3'b010);
    clk_step(3'b010);
    check("single_grant", grant_o, 3'b010);
    check("single_sel",   {1'b0, select_o}, 3'b001);
    clk_step(3'b000);
    check("single_hold",  grant_o, 3'b010);
    clk_step(3'b000);
    check("single_idle_grant", grant_o, 3'b000);
    check("single_idle_busy",  {2'b00, busy_o}, 3'b000);

    // All three requesting, each owner drops for one cycle after two grants
    do_reset(3'b111);
    for (int j = 0; j < 9; j++) begin
      clk_step(s2_req[j+1]);
      check($sformatf("rr_order_%0d", j), grant_o, s2_exp[j]);
    end

    // Handoff with no idle bubble: owner 0 drops while requester 2 waits
    do_reset(3'b101);
    clk_step(3'b101);
    check("handoff_own0", grant_o, 3'b001);
    clk_step(3'b100);
    check("handoff_hold0", grant_o, 3'b001);
    clk_step(3'b100);
    check("handoff_grant2", grant_o, 3'b100);
    check("handoff_sel2",   {1'b0, select_o}, 3'b010);

    // Asynchronous reset between edges while requester 2 owns the grant
    #1 rst_i = 1'b0;
    #1;
    check("async_rst_grant", grant_o, 3'b000);
    check("async_rst_sel",   {1'b0, select_o}, 3'b000);
    check("async_rst_busy",  {2'b00, busy_o}, 3'b000);
    req_i = 3'b111;
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    clk_step(3'b111);
    check("post_rst_first", grant_o, 3'b001);

    // Lone owner held for 10 edges, then a competitor appears and stays
    do_reset(3'b001);
    for (int j = 0; j < 20; j++) begin
      logic [2:0] nxt, exp;
      nxt = (j < 9) ? 3'b001 : (j < 18) ? 3'b011 : 3'b010;
      if (TIMEOUT_ON) begin
        if      (j < 10) exp = 3'b001;
        else if (j < 14) exp = 3'b010;
        else if (j < 18) exp = 3'b001;
        else             exp = 3'b010;
      end else begin
        exp = (j < 19) ? 3'b001 : 3'b010;
      end
      clk_step(nxt);
      check($sformatf("hold_%0d", j), grant_o, exp);
    end

    @(posedge clk_i);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_rr_3to1.md
# arb_rr_3to1

Round-robin arbiter that shares one 3-input datapath resource (a 3-to-1 operand/address mux feeding a shared port) among three requesters. Issues a registered one-hot grant and the matching 2-bit mux select, holds the grant while the winner keeps requesting, and rotates priority on release. Sits directly in front of the 3-to-1 mux; its `select_o` drives the mux select input.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles before preemption when others wait; legal range 1..255; active only with `ARB_TIMEOUT_EN`.
- `clk_i` input 1: single clock, rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `req_i` input 3: request per requester; bit k = requester k; level-sensitive.
- `grant_o` output 3: one-hot grant, registered; 3'b000 when idle.
- `select_o` output 2: mux select; 2'b00/2'b01/2'b10 = requester 0/1/2; never 2'b11.
- `busy_o` output 1: high while any grant is active.

## Operation
- States: IDLE, GRANT. The granted index is held in a 2-bit register `owner`.
- Priority pointer `ptr` (0..2): the search order is ptr, ptr+1, ptr+2 mod 3. The first requester asserted in that order wins.
- IDLE:
  - If `req_i != 0`, the next edge enters GRANT with the winner's grant and select registered.
  - Otherwise stay in IDLE.
- GRANT(k), owner releases (`req_i[k]` == 0):
  - `ptr` <= k+1 mod 3.
  - If other requests are pending, the winner (searched from k+1) is granted on the same edge with no idle bubble.
  - Otherwise go to IDLE.
- GRANT(k), owner holds: the grant stays on k (subject to timeout, see Configuration).
- A non-granted requester dropping `req_i` before it is served has no effect. No request is latched; requests are level-sensitive.
- Idle outputs: `grant_o` = 000, `select_o` = 00, `busy_o` = 0.
- `select_o` always equals the encoded `grant_o` when busy. Both come from the same register update.
- Reset values:
  - `grant_o` = 000, `select_o` = 00, `busy_o` = 0.
  - `ptr` = 0, state = IDLE, hold counter = 0.

## Timing
- Arbitration latency: a request seen at edge N in IDLE gives the grant visible after edge N (one cycle).
- Release latency: the owner drops `req_i` before edge N, and the grant moves or clears at edge N.
- Back-to-back handoff: zero idle cycles between owners.
- Simultaneous requests from reset: `req_i` = 111 grants requester 0 first, then 1, then 2.
- Reset asserted mid-grant: outputs clear immediately (asynchronous). After deassertion, the first arbitration uses `ptr` = 0.
- Reset deassertion is synchronized externally. The block itself only requires that `rst_i` is released away from the clock edge.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A hold counter of width clog2(`MAX_HOLD`+1) clears on every new grant and increments each GRANT cycle.
  - When the counter equals `MAX_HOLD`-1 and another requester is pending, the next edge preempts: `ptr` <= k+1 and the next winner is granted, even though `req_i[k]` is still high.
  - With no other requester pending, the counter saturates and the grant is kept.
  - A preempted requester re-competes normally.
- `ARB_TIMEOUT_EN` undefined: no counter is built, `MAX_HOLD` is ignored, and a grant lasts until the owner deasserts `req_i`.

## Structure
- Shared package `arb_pkg` contains:
  - State enum (IDLE, GRANT).
  - Select encodings `SEL_REQ0`=2'b00, `SEL_REQ1`=2'b01, `SEL_REQ2`=2'b10.
  - Constant `ARB_N`=3.
- Sub-module `arb_rr_pick`: a combinational round-robin picker.
  - Inputs: `req[2:0]`, `ptr[1:0]`, and a 3-bit exclude mask.
  - Outputs: `found` and `idx[1:0]`.
  - The top instantiates it once. The exclude mask removes the current owner during release and timeout search.

## Test plan
- Single request: `req_i` = 010 from IDLE gives `grant_o` = 010 and `select_o` = 01 one cycle later. Drop req: the next edge returns 000/00 and `busy_o` = 0.
- All three requesting after reset: each owner drops its req after 2 cycles and re-raises it 1 cycle later. The grant order is 0, 1, 2, 0, … with no idle cycles between owners.
- Handoff while idle-free: owner 0 active and `req_i` = 101. Drop bit 0, and `grant_o` goes to 100 (`select_o` = 10) on the same edge.
- Timeout (`ARB_TIMEOUT_EN`, `MAX_HOLD`=4): `req_i` = 011 held high constantly. Grants alternate 001 ×4 cycles, 010 ×4 cycles, repeating. With only `req_i` = 001, the grant is held indefinitely.
- Timeout compiled out: same stimulus as the previous scenario. `grant_o` stays 001 until `req_i[0]` drops.
- Asynchronous reset mid-grant: `rst_i` pulled low between edges while `grant_o` = 100. Outputs go to 000/00 immediately. After release with `req_i` = 111, requester 0 wins first.
